// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch sequencer state encoding.
package cpu_pkg;

  localparam int          ADDR_W      = 32;
  localparam int          INSTR_W     = 32;
  localparam int          QUEUE_DEPTH = 2;
  localparam logic [31:0] RESET_PC    = 32'd0;
  localparam logic [31:0] MEM_LAST    = 32'd65535;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries. Count-based circular buffer with a
// registered head copy so the head fields hold their last value when empty.
// Flush beats push and pop in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             pop_s, push_s, wr_en_s;

  // Next-state pointers, count and head copy; flush empties without touching the head.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    head_d   = head_q;
    wr_en_s  = 1'b0;
    pop_s    = pop_i && (count_q != {CNT_W{1'b0}});
    push_s   = push_i && ((count_q < CNT_W'(DEPTH)) || pop_s);
    if (flush_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
      valid_d  = 1'b0;
    end else begin
      wr_en_s = push_s;
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
      valid_d = (count_d != {CNT_W{1'b0}});
      // The new head is the incoming word when nothing older survives this cycle.
      if (count_d == {CNT_W{1'b0}}) begin
        head_d = head_q;
      end else if ((count_q == {CNT_W{1'b0}}) || (pop_s && (count_q == CNT_W'(1)))) begin
        head_d = push_data_i;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Queue storage and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      valid_q  <= 1'b0;
      head_q   <= {WIDTH{1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: fetches one word per cycle from the
// combinational program memory into a prefetch queue and hands
// {pc, instr} to decode; handles redirect, halt and out-of-range faults.
module fetch_sequencer import cpu_pkg::*; #(
  parameter int                ADDR_W      = cpu_pkg::ADDR_W,
  parameter int                INSTR_W     = cpu_pkg::INSTR_W,
  parameter int                QUEUE_DEPTH = cpu_pkg::QUEUE_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(cpu_pkg::RESET_PC),
  parameter logic [ADDR_W-1:0] MEM_LAST    = ADDR_W'(cpu_pkg::MEM_LAST)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_adr,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               halted,
  output logic               fault
);

  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam int CNT_W   = ((QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1) + 1;

  seq_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               halted_q, fault_q;
  logic               push_s, flush_s, pop_s, free_s;
  logic [CNT_W-1:0]   count_s;
  logic [ENTRY_W-1:0] head_s;

  assign pop_s  = out_valid && out_ready;
  assign free_s = (count_s < CNT_W'(QUEUE_DEPTH)) || pop_s;

  // Next state, next pc and push/flush decisions in redirect > fault > halt > range > fetch order.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push_s  = 1'b0;
    flush_s = 1'b0;
    if (redirect_valid) begin
      flush_s = 1'b1;
      pc_d    = redirect_pc;
      if (redirect_pc > MEM_LAST) begin
        state_d = ST_FAULT;
      end else if (halt_req) begin
        state_d = ST_HALTED;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        ST_RUN, ST_HALTED: begin
          if (halt_req) begin
            state_d = ST_HALTED;
          end else if (pc_q > MEM_LAST) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_RUN;
            if (free_s) begin
              push_s = 1'b1;
              pc_d   = pc_q + ADDR_W'(1);
            end else begin
              push_s = 1'b0;
            end
          end
        end
        default: begin
          state_d = ST_FAULT;
        end
      endcase
    end
  end

  // Sequencer registers; halted/fault are decoded from the next state so they track the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= (state_d == ST_HALTED);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_s),
    .push_i      (push_s),
    .push_data_i ({pc_q, imem_instruction}),
    .pop_i       (pop_s),
    .valid_o     (out_valid),
    .head_o      (head_s),
    .count_o     (count_s)
  );

  assign imem_adr  = pc_q;
  assign out_pc    = head_s[ENTRY_W-1:INSTR_W];
  assign out_instr = head_s[INSTR_W-1:0];
  assign halted    = halted_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a queue-based reference model fills
// the expected-delivery queue at each clock edge, a monitor on the falling
// edge compares DUT outputs with it and retires entries on handshakes.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC   = 32'd0;
  localparam logic [31:0] LAST     = 32'd65535;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_adr;
  logic [31:0] imem_instruction;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        halt_req = 1'b0;
  logic        halted;
  logic        fault;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  // Reference model: expected queue contents, pc and state (0 run, 1 halted, 2 fault).
  logic [63:0] exp_q[$];
  logic [31:0] m_pc = RST_PC;
  int          m_state = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign imem_instruction = mem_word(imem_adr);

  fetch_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .imem_adr         (imem_adr),
    .imem_instruction (imem_instruction),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .halt_req         (halt_req),
    .halted           (halted),
    .fault            (fault)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model update at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_pc = RST_PC;
      m_state = 0;
    end else if (redirect_valid) begin
      exp_q.delete();
      m_pc = redirect_pc;
      m_state = (redirect_pc > LAST) ? 2 : (halt_req ? 1 : 0);
    end else if (m_state == 2) begin
      m_state = 2;
    end else if (halt_req) begin
      m_state = 1;
    end else if (m_pc > LAST) begin
      m_state = 2;
    end else begin
      m_state = 0;
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd1;
      end
    end
  end

  // Monitor: compare outputs on the falling edge and retire accepted heads.
  always @(negedge clk) begin
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
    chk("imem_adr", {32'd0, imem_adr}, {32'd0, m_pc});
    chk("halted", {63'd0, halted}, {63'd0, m_state == 1});
    chk("fault", {63'd0, fault}, {63'd0, m_state == 2});
    if (exp_q.size() != 0) begin
      chk("head", {out_pc, out_instr}, exp_q[0]);
      if (out_ready && !redirect_valid && !rst) begin
        void'(exp_q.pop_front());
        delivered++;
      end
    end
  end

  task automatic drive(input int n, input logic rdy, input logic rv,
                       input logic [31:0] rpc, input logic hlt);
    for (int i = 0; i < n; i++) begin
      out_ready      = rdy;
      redirect_valid = rv && (i == 0);
      redirect_pc    = rpc;
      halt_req       = hlt;
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic        r_rdy;
    logic        r_rv;
    logic [31:0] r_pc;
    logic        r_halt;
    r_halt = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_pc", {32'd0, out_pc}, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    chk("rst_imem_adr", {32'd0, imem_adr}, {32'd0, RST_PC});
    rst = 1'b0;

    // Straight-line fetch, backpressure, redirect while full.
    drive(4, 1'b1, 1'b0, 32'd0, 1'b0);
    drive(5, 1'b0, 1'b0, 32'd0, 1'b0);
    drive(4, 1'b1, 1'b0, 32'd0, 1'b0);
    drive(3, 1'b0, 1'b0, 32'd0, 1'b0);
    drive(4, 1'b1, 1'b1, 32'd5, 1'b0);
    // Halt and resume.
    drive(4, 1'b1, 1'b1, 32'd3, 1'b0);
    drive(5, 1'b1, 1'b0, 32'd0, 1'b1);
    drive(4, 1'b1, 1'b0, 32'd0, 1'b0);
    // Fault boundary: last legal word, beyond range, then recovery.
    drive(6, 1'b1, 1'b1, LAST, 1'b0);
    drive(3, 1'b1, 1'b1, 32'd70000, 1'b0);
    drive(4, 1'b1, 1'b1, 32'd4, 1'b0);
    // Redirect while halt is held lands in HALTED.
    drive(3, 1'b1, 1'b1, 32'd20, 1'b1);
    drive(3, 1'b1, 1'b0, 32'd0, 1'b0);

    // Async reset mid-stream with a full queue and halted set.
    drive(4, 1'b0, 1'b0, 32'd0, 1'b0);
    drive(2, 1'b0, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_halted", {63'd0, halted}, 64'd0);
    chk("arst_fault", {63'd0, fault}, 64'd0);
    chk("arst_imem_adr", {32'd0, imem_adr}, {32'd0, RST_PC});
    halt_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      r_rdy = ($urandom % 4) != 0;
      r_rv  = ($urandom % 20) == 0;
      case ($urandom % 4)
        0:       r_pc = $urandom % 64;
        1:       r_pc = LAST - ($urandom % 3);
        2:       r_pc = LAST + 32'd1 + ($urandom % 10);
        default: r_pc = $urandom % 1000;
      endcase
      if (($urandom % 12) == 0) begin
        r_halt = ~r_halt;
      end
      drive(1, r_rdy, r_rv, r_pc, r_halt);
    end
    drive(6, 1'b1, 1'b1, 32'd100, 1'b0);

    chk("deliveries", {63'd0, delivered > 200}, 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
